// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 4-digit common-anode scanned display of A, B, compare flag and result.
// Optional result-digit blink while A==B is enabled by defining SEG7_EQUAL_BLINK_EN.
module seg7_scan_display #(
    parameter int CLK_DIV = 50000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] val_a,
    input  logic [2:0] val_b,
    input  logic [2:0] result,
    output logic       loaded,
    output logic [3:0] an,
    output logic [6:0] seg
);
    typedef enum logic {BLANK, SHOW} state_t;
    localparam int MAXC = CLK_DIV > BLANK_CYC ? CLK_DIV : BLANK_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [6:0] DIGITS [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic [2:0] disp_a, disp_b, disp_r, pend_a, pend_b, pend_r;
    logic pend_v, blank_done, show_done, xfer, hide;
    logic [6:0] flag, digit;
    logic [3:0] anode;
    assign blank_done = cnt == CW'(BLANK_CYC - 1);
    assign show_done = cnt == CW'(CLK_DIV - 1);
    assign xfer = state == SHOW && show_done && pend_v;
`ifdef SEG7_EQUAL_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] fcnt;
    logic blink;
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            blink <= 1'b0;
        end else if (state == SHOW && show_done && idx == 2'd3) begin
            fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
            blink <= fcnt == FW'(BLINK_FRAMES - 1) ? ~blink : blink;
        end
    end
    assign hide = blink && disp_a == disp_b;
`else
    assign hide = 1'b0;
`endif
    always_comb begin
        flag = disp_a > disp_b ? 7'b0001000 : disp_b > disp_a ? 7'b0000011 : 7'b0110111;
        digit = idx == 2'd0 ? (hide ? 7'b1111111 : DIGITS[disp_r]) :
                idx == 2'd1 ? flag :
                idx == 2'd2 ? DIGITS[disp_b] : DIGITS[disp_a];
        anode = ~(4'b0001 << idx);
    end
    // Pending values only reach the display on a SHOW->BLANK edge, so a lit digit never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            cnt <= '0;
            idx <= 2'd0;
            {disp_a, disp_b, disp_r} <= '0;
            {pend_a, pend_b, pend_r} <= '0;
            pend_v <= 1'b0;
            an <= 4'b1111;
            seg <= 7'b1111111;
            loaded <= 1'b0;
        end else begin
            loaded <= xfer;
            if (xfer) {disp_a, disp_b, disp_r} <= {pend_a, pend_b, pend_r};
            if (load) {pend_a, pend_b, pend_r} <= {val_a, val_b, result};
            pend_v <= load | (pend_v & ~xfer);
            if (state == BLANK) begin
                cnt <= blank_done ? '0 : cnt + 1'b1;
                if (blank_done) begin
                    state <= SHOW;
                    an <= anode;
                    seg <= digit;
                end
            end else begin
                cnt <= show_done ? '0 : cnt + 1'b1;
                if (show_done) begin
                    state <= BLANK;
                    idx <= idx + 2'd1;
                    an <= 4'b1111;
                    seg <= 7'b1111111;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed corners plus random loads/resets against a timeline model.
module tb_seg7_scan_display;
    localparam int CD = 4, BC = 2, BF = 2;
    localparam int P = CD + BC, FRAME = 4 * P;
    logic clk = 1'b0, rst, load, loaded;
    logic [2:0] val_a, val_b, result;
    logic [3:0] an;
    logic [6:0] seg;
    int checks = 0, errors = 0;
    int t;
    logic [2:0] m_a, m_b, m_r, p_a, p_b, p_r;
    logic pv, exp_loaded;
    logic [6:0] codes [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    logic [3:0] an_codes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg7_scan_display #(.CLK_DIV(CD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .load(load), .val_a(val_a), .val_b(val_b),
        .result(result), .loaded(loaded), .an(an), .seg(seg));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %b expected %b", tag, t, got, exp);
        end
    endtask
    function automatic logic [6:0] exp_seg(int k);
        logic hidden;
        hidden = 1'b0;
`ifdef SEG7_EQUAL_BLINK_EN
        hidden = ((t / FRAME) / BF) % 2 == 1 && m_a == m_b;
`endif
        case (k)
            0: return hidden ? 7'b1111111 : codes[m_r];
            1: return m_a > m_b ? 7'b0001000 : m_b > m_a ? 7'b0000011 : 7'b0110111;
            2: return codes[m_b];
            default: return codes[m_a];
        endcase
    endfunction
    task automatic cyc(input logic r, input logic l, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] res);
        int k, o;
        k = (t % FRAME) / P;
        o = t % P;
        check("an", {4'b0, an}, {4'b0, o < BC ? 4'b1111 : an_codes[k]});
        check("seg", {1'b0, seg}, {1'b0, o < BC ? 7'b1111111 : exp_seg(k)});
        check("loaded", {7'b0, loaded}, {7'b0, exp_loaded});
        rst = r; load = l; val_a = a; val_b = b; result = res;
        @(posedge clk);
        if (rst) begin
            t = 0; pv = 1'b0; exp_loaded = 1'b0;
            {m_a, m_b, m_r} = '0;
        end else begin
            exp_loaded = (t % P == P - 1) && pv;
            if (exp_loaded) begin
                {m_a, m_b, m_r} = {p_a, p_b, p_r};
                pv = 1'b0;
            end
            if (load) begin
                {p_a, p_b, p_r} = {val_a, val_b, result};
                pv = 1'b1;
            end
            t++;
        end
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom));
    endtask
    initial begin
        rst = 1'b1; load = 1'b1; val_a = 3'd7; val_b = 3'd1; result = 3'd7;
        t = 0; pv = 1'b0; exp_loaded = 1'b0;
        {m_a, m_b, m_r, p_a, p_b, p_r} = '0;
        @(posedge clk);
        @(negedge clk);
        cyc(1'b1, 1'b1, 3'd6, 3'd2, 3'd6);
        idle(3);
        cyc(1'b0, 1'b1, 3'd5, 3'd3, 3'd5);
        idle(4);
        cyc(1'b0, 1'b1, 3'd2, 3'd6, 3'd6);
        cyc(1'b0, 1'b1, 3'd1, 3'd4, 3'd4);
        idle(10);
        cyc(1'b0, 1'b1, 3'd6, 3'd6, 3'd0);
        idle(2);
        cyc(1'b0, 1'b1, 3'd7, 3'd2, 3'd7);
        idle(39);
        cyc(1'b0, 1'b1, 3'd4, 3'd1, 3'd4);
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        idle(20);
        cyc(1'b0, 1'b1, 3'd3, 3'd3, 3'd0);
        idle(260);
        cyc(1'b0, 1'b1, 3'd3, 3'd5, 3'd5);
        idle(120);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                3'($urandom), 3'($urandom), 3'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
